// File: rtl/branch_resolve_unit_pkg.sv
// Shared pipeline definitions for the ID-stage branch resolver.
//   XLEN      : datapath / PC width
//   FWD_*     : encoding of the EX/MEM->ID forwarding selects (F1/F2)
//   state_e   : resolver FSM state (IDLE, STALL)
package branch_resolve_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of all ID-stage branch-resolution signals.
//   slave  : seen by branch_resolve_unit (decode/forwarding inputs, control outputs)
//   master : seen by whatever drives the ID stage (here, the testbench)
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic             IF_ID_branch;
  logic             IF_ID_bne;
  logic [XLEN-1:0]  IF_ID_pc_plus4;
  logic [XLEN-1:0]  IF_ID_imm;
  logic [XLEN-1:0]  rs_data;
  logic [XLEN-1:0]  rt_data;
  logic [1:0]       F1;
  logic [1:0]       F2;
  logic [XLEN-1:0]  ex_result;
  logic [XLEN-1:0]  mem_result;
  logic             ID_EX_MemRead;
  logic             EX_MEM_MemRead;

  logic             stall;
  logic             pc_src;
  logic [XLEN-1:0]  branch_target;
  logic             flush_if_id;
  logic             last_taken;
  logic [CNT_W-1:0] resolve_count;
  logic [CNT_W-1:0] taken_count;
  logic [CNT_W-1:0] stall_count;
  logic             err;

  modport slave (
    input  IF_ID_branch, IF_ID_bne, IF_ID_pc_plus4, IF_ID_imm,
    input  rs_data, rt_data, F1, F2, ex_result, mem_result,
    input  ID_EX_MemRead, EX_MEM_MemRead,
    output stall, pc_src, branch_target, flush_if_id, last_taken,
    output resolve_count, taken_count, stall_count, err
  );

  modport master (
    output IF_ID_branch, IF_ID_bne, IF_ID_pc_plus4, IF_ID_imm,
    output rs_data, rt_data, F1, F2, ex_result, mem_result,
    output ID_EX_MemRead, EX_MEM_MemRead,
    input  stall, pc_src, branch_target, flush_if_id, last_taken,
    input  resolve_count, taken_count, stall_count, err
  );

endinterface

// File: rtl/branch_resolve_unit_fwd_operand_mux.sv
// One branch operand: choose regfile / EX / MEM value from a forwarding select.
//   sel         : forwarding select (FWD_REG / FWD_EX / FWD_MEM; 2'b11 illegal)
//   reg_data    : register-file read
//   ex_result   : ALU output in EX;  ex_is_load  : that instruction is a load
//   mem_result  : ALU result in MEM; mem_is_load : that instruction is a load
//   operand     : selected value
//   ready       : value is available this cycle (not a pending load)
//   illegal     : sel was 2'b11 (falls back to reg_data)
module fwd_operand_mux
  import branch_resolve_unit_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] reg_data,
  input  logic [W-1:0] ex_result,
  input  logic [W-1:0] mem_result,
  input  logic         ex_is_load,
  input  logic         mem_is_load,
  output logic [W-1:0] operand,
  output logic         ready,
  output logic         illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    operand = reg_data;
    ready   = 1'b1;
    illegal = 1'b0;
    unique case (sel)
      FWD_REG: operand = reg_data;
      FWD_EX: begin
        operand = ex_result;
        ready   = ~ex_is_load;   // load data appears only after MEM
      end
      FWD_MEM: begin
        operand = mem_result;
        ready   = ~mem_is_load;  // mem_result is the address, not the loaded data
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage beq/bne resolver with load-use stall, statistics and sticky error.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : branch_resolve_unit_if.slave -- decode/forwarding inputs,
//                stall / pc_src / branch_target / flush_if_id control outputs,
//                last_taken, saturating resolve/taken/stall counters, err
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int W         = XLEN,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_resolve_unit_if.slave   bus
);

  logic [W-1:0] op_a, op_b;
  logic         ready_a, ready_b, illegal_a, illegal_b;
  logic         is_br, hazard, resolve, taken;

  fwd_operand_mux #(.W(W)) u_mux_a (
    .sel(bus.F1), .reg_data(bus.rs_data),
    .ex_result(bus.ex_result), .mem_result(bus.mem_result),
    .ex_is_load(bus.ID_EX_MemRead), .mem_is_load(bus.EX_MEM_MemRead),
    .operand(op_a), .ready(ready_a), .illegal(illegal_a)
  );

  fwd_operand_mux #(.W(W)) u_mux_b (
    .sel(bus.F2), .reg_data(bus.rt_data),
    .ex_result(bus.ex_result), .mem_result(bus.mem_result),
    .ex_is_load(bus.ID_EX_MemRead), .mem_is_load(bus.EX_MEM_MemRead),
    .operand(op_b), .ready(ready_b), .illegal(illegal_b)
  );

  assign is_br   = bus.IF_ID_branch | bus.IF_ID_bne;
  assign hazard  = is_br & ~(ready_a & ready_b);
  assign resolve = is_br & ~hazard;
  assign taken   = resolve & (bus.IF_ID_branch ? (op_a == op_b) : (op_a != op_b));

  assign bus.stall         = hazard;
  assign bus.pc_src        = taken;
  assign bus.flush_if_id   = taken;
  assign bus.branch_target = bus.IF_ID_pc_plus4 + {bus.IF_ID_imm[W-3:0], 2'b00};

  // State and statistics
  state_e           state_q, state_d;
  logic [1:0]       stall_cnt_q, stall_cnt_d;    // consecutive stall cycles, sat. at 3
  logic             err_q, err_d;
  logic             last_taken_q, last_taken_d;
  logic [CNT_W-1:0] resolve_count_q, resolve_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q | (is_br & (illegal_a | illegal_b));
    unique case (state_q)
      IDLE: begin
        if (hazard) begin
          state_d     = STALL;
          stall_cnt_d = 2'd1;
          if (MAX_STALL < 1) err_d = 1'b1;
        end
      end
      STALL: begin
        if (!is_br) begin
          // Branch squashed underneath us: abandon without resolving.
          state_d     = IDLE;
          stall_cnt_d = 2'd0;
        end else if (hazard) begin
          if (stall_cnt_q != 2'd3) stall_cnt_d = stall_cnt_q + 2'd1;
          if (int'(stall_cnt_q) + 1 > MAX_STALL) err_d = 1'b1;
        end else begin
          state_d     = IDLE;
          stall_cnt_d = 2'd0;
        end
      end
      default: begin
        state_d     = IDLE;
        stall_cnt_d = 2'd0;
      end
    endcase

    last_taken_d    = resolve ? taken : last_taken_q;
    resolve_count_d = (resolve && resolve_count_q != '1) ? resolve_count_q + CNT_W'(1)
                                                         : resolve_count_q;
    taken_count_d   = (taken && taken_count_q != '1) ? taken_count_q + CNT_W'(1)
                                                     : taken_count_q;
    stall_count_d   = (hazard && stall_count_q != '1) ? stall_count_q + CNT_W'(1)
                                                      : stall_count_q;
  end

  // NOTE: non-blocking assignments for every flop; reset is asynchronous so a
  // mid-stall reset clears state immediately rather than at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      stall_cnt_q     <= 2'd0;
      err_q           <= 1'b0;
      last_taken_q    <= 1'b0;
      resolve_count_q <= '0;
      taken_count_q   <= '0;
      stall_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
      err_q           <= err_d;
      last_taken_q    <= last_taken_d;
      resolve_count_q <= resolve_count_d;
      taken_count_q   <= taken_count_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign bus.last_taken    = last_taken_q;
  assign bus.resolve_count = resolve_count_q;
  assign bus.taken_count   = taken_count_q;
  assign bus.stall_count   = stall_count_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

  localparam int XLEN      = 32;
  localparam int CNT_W     = 16;
  localparam int MAX_STALL = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.W(XLEN), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: consecutive stall count instead of an FSM.
  int m_resolve, m_taken, m_stall, m_consec;
  bit m_last, m_err;
  bit e_br, e_hazard, e_resolve, e_taken, e_illegal;
  logic [31:0] e_target;

  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] reg_v);
    if (f == 2'd1) return bus.ex_result;
    if (f == 2'd2) return bus.mem_result;
    return reg_v;
  endfunction

  function automatic bit pending(input logic [1:0] f);
    return (f == 2'd1 && bus.ID_EX_MemRead) || (f == 2'd2 && bus.EX_MEM_MemRead);
  endfunction

  task automatic model_eval();
    logic [31:0] a, b;
    longint sum;
    a = pick(bus.F1, bus.rs_data);
    b = pick(bus.F2, bus.rt_data);
    e_br      = bus.IF_ID_branch || bus.IF_ID_bne;
    e_illegal = (bus.F1 == 2'd3) || (bus.F2 == 2'd3);
    e_hazard  = e_br && (pending(bus.F1) || pending(bus.F2));
    e_resolve = e_br && !e_hazard;
    e_taken   = e_resolve && (bus.IF_ID_branch ? (a == b) : (a != b));
    sum       = longint'(bus.IF_ID_pc_plus4) + longint'(bus.IF_ID_imm) * 4;
    e_target  = sum[31:0];
  endtask

  task automatic model_clock();
    if (e_hazard) begin
      if (m_stall < CNT_MAX) m_stall++;
      m_consec++;
      if (m_consec > MAX_STALL) m_err = 1'b1;
    end else begin
      m_consec = 0;
    end
    if (e_resolve) begin
      if (m_resolve < CNT_MAX) m_resolve++;
      m_last = e_taken;
    end
    if (e_taken && m_taken < CNT_MAX) m_taken++;
    if (e_br && e_illegal) m_err = 1'b1;
  endtask

  task automatic model_reset();
    m_resolve = 0; m_taken = 0; m_stall = 0; m_consec = 0;
    m_last = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, ".last_taken"},    bus.last_taken,    m_last);
    check({pfx, ".resolve_count"}, bus.resolve_count, m_resolve);
    check({pfx, ".taken_count"},   bus.taken_count,   m_taken);
    check({pfx, ".stall_count"},   bus.stall_count,   m_stall);
    check({pfx, ".err"},           bus.err,           m_err);
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step(input string pfx);
    #1;
    model_eval();
    check({pfx, ".stall"},       bus.stall,       e_hazard);
    check({pfx, ".pc_src"},      bus.pc_src,      e_taken);
    check({pfx, ".flush_if_id"}, bus.flush_if_id, e_taken);
    if (e_br) check({pfx, ".branch_target"}, bus.branch_target, e_target);
    @(posedge clk);
    model_clock();
    #1;
    check_regs(pfx);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.IF_ID_branch = 0; bus.IF_ID_bne = 0;
    bus.IF_ID_pc_plus4 = 32'h100; bus.IF_ID_imm = 32'h4;
    bus.rs_data = 0; bus.rt_data = 0; bus.F1 = 2'd0; bus.F2 = 2'd0;
    bus.ex_result = 0; bus.mem_result = 0;
    bus.ID_EX_MemRead = 0; bus.EX_MEM_MemRead = 0;
  endtask

  // Entered and left at a negedge.
  task automatic do_reset(input string pfx);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_regs(pfx);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset("reset");

    // Taken beq, regfile operands.
    bus.IF_ID_branch = 1; bus.rs_data = 5; bus.rt_data = 5;
    bus.IF_ID_pc_plus4 = 32'h100; bus.IF_ID_imm = 32'h4;
    #1;
    check("t1.target_const", bus.branch_target, 32'h110);
    check("t1.pc_src_const", bus.pc_src, 1'b1);
    step("t1");
    check("t1.resolve_const", bus.resolve_count, 1);
    check("t1.taken_const", bus.taken_count, 1);

    // bne with EX forward, equal operands -> not taken.
    idle_inputs();
    bus.IF_ID_bne = 1; bus.F1 = 2'd1; bus.ex_result = 7; bus.rt_data = 7;
    step("t2");
    check("t2.last_taken_const", bus.last_taken, 1'b0);

    // Load in EX then MEM feeding beq: two stalls then resolve.
    do_reset("t3.rst");
    idle_inputs();
    bus.IF_ID_branch = 1; bus.rs_data = 9; bus.rt_data = 9; bus.mem_result = 9;
    bus.F1 = 2'd1; bus.ID_EX_MemRead = 1;
    step("t3.c1");
    bus.F1 = 2'd2; bus.ID_EX_MemRead = 0; bus.EX_MEM_MemRead = 1;
    step("t3.c2");
    bus.F1 = 2'd0; bus.EX_MEM_MemRead = 0;
    #1;
    check("t3.pc_src_const", bus.pc_src, 1'b1);
    step("t3.c3");
    check("t3.stall_count_const", bus.stall_count, 2);
    check("t3.err_const", bus.err, 1'b0);

    // Load held in MEM for three cycles: err on the third stall, sticky.
    idle_inputs();
    bus.IF_ID_branch = 1; bus.F2 = 2'd2; bus.EX_MEM_MemRead = 1;
    for (int i = 0; i < 3; i++) step("t4.stall");
    check("t4.err_const", bus.err, 1'b1);
    idle_inputs();
    step("t4.drop");
    check("t4.err_sticky", bus.err, 1'b1);

    // Illegal select: err, operand A falls back to rs_data.
    do_reset("t5.rst");
    idle_inputs();
    bus.IF_ID_branch = 1; bus.F1 = 2'd3; bus.rs_data = 32'hA5;
    bus.rt_data = 32'hA5; bus.ex_result = 1; bus.mem_result = 2;
    step("t5");
    check("t5.err_const", bus.err, 1'b1);
    check("t5.taken_const", bus.last_taken, 1'b1);

    // Reset in the middle of a stall.
    do_reset("t6.rst0");
    idle_inputs();
    bus.IF_ID_branch = 1; bus.rs_data = 3; bus.rt_data = 3;
    step("t6.taken");
    bus.F1 = 2'd1; bus.ID_EX_MemRead = 1;
    step("t6.stall");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("t6.midrst");
    check("t6.stall_comb", bus.stall, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.IF_ID_pc_plus4 = 32'h200; bus.IF_ID_imm = 32'hFFFF_FFFF;
    step("t6.s1");
    bus.F1 = 2'd2; bus.ID_EX_MemRead = 0; bus.EX_MEM_MemRead = 1; bus.mem_result = 3;
    step("t6.s2");
    bus.F1 = 2'd0; bus.EX_MEM_MemRead = 0;
    #1;
    check("t6.target_neg", bus.branch_target, 32'h1FC);
    step("t6.res");
    check("t6.err_const", bus.err, 1'b0);
    check("t6.stall_count_const", bus.stall_count, 2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int kind;
      if ($urandom_range(0, 299) == 0) do_reset("rnd.rst");
      kind = $urandom_range(0, 3);
      bus.IF_ID_branch   = (kind == 1);
      bus.IF_ID_bne      = (kind == 2);
      bus.IF_ID_pc_plus4 = $urandom();
      bus.IF_ID_imm      = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 64));
      bus.rs_data        = $urandom_range(0, 3);
      bus.rt_data        = $urandom_range(0, 3);
      bus.ex_result      = $urandom_range(0, 3);
      bus.mem_result     = $urandom_range(0, 3);
      bus.F1             = ($urandom_range(0, 99) < 2) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.F2             = ($urandom_range(0, 99) < 2) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.ID_EX_MemRead  = ($urandom_range(0, 2) == 0);
      bus.EX_MEM_MemRead = ($urandom_range(0, 2) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
